nibble_negate_ctrl: RTL and testbench

//   Sequencer that computes the two's complement (or absolute value) of a

---
 rtl/nibble_negate_ctrl_if.sv | 23 ++
 rtl/nibble_negate_ctrl.sv | 94 +++++++++
 tb/tb_nibble_negate_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nibble_negate_ctrl_if.sv
// Producer/consumer handshake bundle for the nibble-serial negate/abs sequencer.
// slave = the sequencer's view, master = the producer/consumer side driving it.
interface nibble_negate_ctrl_if #(parameter int W = 16);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/nibble_negate_ctrl.sv
// Two's complement / absolute value of a W-bit word through one 4-bit invert+increment slice, LSB nibble first.
// Result valid exactly NIBBLES cycles after accept; DONE holds out_data/out_ovf until out_ready, in_ready low meanwhile.
module nibble_negate_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    nibble_negate_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   op_q, res_q, res_nxt, out_data_q;
    logic [CW-1:0]  cnt_q;
    logic           en_q, carry_q, ovf_pend_q, out_ovf_q;
    logic [3:0]     nib, r;
    logic [4:0]     sum;
    logic           carry_nxt, last_nib, accept, out_take, en_in;

    assign accept   = bus.in_valid && (state == S_IDLE);
    assign out_take = bus.out_ready && (state == S_DONE);
    assign last_nib = (cnt_q == CW'(NIBBLES - 1));
    assign en_in    = ~bus.in_mode | bus.in_data[W-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)   state_nxt = S_RUN;
            S_RUN:  if (last_nib) state_nxt = S_DONE;
            S_DONE: if (out_take) state_nxt = S_IDLE;
            default:              state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
        bus.busy      = (state != S_IDLE);
        bus.out_data  = out_data_q;
        bus.out_ovf   = out_ovf_q;
    end

    // One nibble slice; the operand shifts down and the result shifts in from the top.
    always_comb begin
        nib       = op_q[3:0];
        sum       = {1'b0, ~nib} + {4'b0000, carry_q};
        r         = en_q ? sum[3:0] : nib;
        carry_nxt = en_q & sum[4];
        res_nxt   = res_q >> 4;
        res_nxt[W-1 -: 4] = r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            res_q      <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            carry_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= bus.in_data;
            res_q      <= '0;
            cnt_q      <= '0;
            en_q       <= en_in;
            carry_q    <= en_in;
            ovf_pend_q <= en_in & (bus.in_data == MOST_NEG);
        end else if (state == S_RUN) begin
            op_q    <= op_q >> 4;
            res_q   <= res_nxt;
            carry_q <= carry_nxt;
            cnt_q   <= cnt_q + CW'(1);
            // Final carry-out is dropped: 0 negates to 0 without overflow.
            if (last_nib) begin
                out_data_q <= res_nxt;
                out_ovf_q  <= ovf_pend_q;
            end
        end
    end
endmodule

// File: tb/tb_nibble_negate_ctrl.sv
// Directed bench for the nibble-serial negate/abs sequencer, 4-nibble and 1-nibble builds.
module tb_nibble_negate_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nibble_negate_ctrl_if #(.W(16)) if4 ();
    nibble_negate_ctrl_if #(.W(4))  if1 ();

    nibble_negate_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    nibble_negate_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done4(output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!if4.out_valid && k < 20);
    endtask

    task automatic run_op4(input string nm, input logic mode, input logic [15:0] data,
                           input logic [15:0] exp_d, input logic exp_o);
        int k;
        if4.in_valid = 1'b1;
        if4.in_mode  = mode;
        if4.in_data  = data;
        chk({nm, " in_ready"}, if4.in_ready, 1);
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        chk({nm, " busy"}, if4.busy, 1);
        wait_done4(k);
        chk({nm, " latency"}, k, 4);
        chk({nm, " data"}, if4.out_data, exp_d);
        chk({nm, " ovf"}, if4.out_ovf, exp_o);
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
        chk({nm, " idle_after"}, {if4.out_valid, if4.in_ready}, 2'b01);
    endtask

    initial begin
        int k;
        logic [3:0] d;
        logic [3:0] e;
        vecs[0] = '{1'b0, 16'h0001, 16'hFFFF, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 16'h8000, 16'h8000, 1'b1};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h8001, 1'b0};
        vecs[4] = '{1'b1, 16'hFFF6, 16'h000A, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 1'b0};
        vecs[6] = '{1'b1, 16'h8000, 16'h8000, 1'b1};
        vecs[7] = '{1'b0, 16'h00F0, 16'hFF10, 1'b0};
        vecs[8] = '{1'b0, 16'h1234, 16'hEDCC, 1'b0};
        vecs[9] = '{1'b1, 16'h8001, 16'h7FFF, 1'b0};

        if4.in_valid = 1'b0; if4.in_mode = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_mode = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;

        #12;
        chk("reset in_ready",  if4.in_ready, 1);
        chk("reset out_valid", if4.out_valid, 0);
        chk("reset out_data",  if4.out_data, 0);
        chk("reset out_ovf",   if4.out_ovf, 0);
        chk("reset busy",      if4.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op4($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data, vecs[i].exp_data, vecs[i].exp_ovf);

        // Backpressure: hold DONE for 3 cycles with a second operand waiting.
        if4.in_valid = 1'b1; if4.in_mode = 1'b0; if4.in_data = 16'h0001;
        @(posedge clk); #1;
        if4.in_data = 16'h0002;
        wait_done4(k);
        chk("bp latency", k, 4);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d valid", c), if4.out_valid, 1);
            chk($sformatf("bp hold%0d data", c), if4.out_data, 16'hFFFF);
            chk($sformatf("bp hold%0d in_ready", c), if4.in_ready, 0);
        end
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
        chk("bp release valid", if4.out_valid, 0);
        chk("bp release in_ready", if4.in_ready, 1);
        chk("bp release data kept", if4.out_data, 16'hFFFF);
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        chk("bp second accepted", if4.busy, 1);
        wait_done4(k);
        chk("bp second latency", k, 4);
        chk("bp second data", if4.out_data, 16'hFFFE);
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;

        // Reset mid-operation, after nibble 1 has been processed.
        if4.in_valid = 1'b1; if4.in_mode = 1'b0; if4.in_data = 16'h1234;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst in_ready",  if4.in_ready, 1);
        chk("midrst out_valid", if4.out_valid, 0);
        chk("midrst out_data",  if4.out_data, 0);
        chk("midrst out_ovf",   if4.out_ovf, 0);
        chk("midrst busy",      if4.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst no result", if4.out_valid, 0);
        run_op4("after_rst", 1'b0, 16'h00F0, 16'hFF10, 1'b0);

        // Single-nibble build must behave as the 4-bit complement unit.
        for (int i = 0; i < 16; i++) begin
            d = i[3:0];
            e = 4'd0 - d;
            if1.in_valid = 1'b1; if1.in_mode = 1'b0; if1.in_data = d;
            @(posedge clk); #1;
            if1.in_valid = 1'b0;
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (!if1.out_valid && k < 20);
            chk($sformatf("n1 d%0d latency", i), k, 1);
            chk($sformatf("n1 d%0d data", i), if1.out_data, e);
            chk($sformatf("n1 d%0d ovf", i), if1.out_ovf, (d == 4'b1000) ? 1 : 0);
            if1.out_ready = 1'b1;
            @(posedge clk); #1;
            if1.out_ready = 1'b0;
            repeat (50 - 2 - k) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
